// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths, segment constants and digit slice helper for the 7-segment display path.
package seg7_pkg;
  localparam int DIGITS = 6;
  localparam int SEG_W = 7;
  localparam int DISP_W = 42;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;
  function automatic logic [SEG_W-1:0] digit_slice(input logic [DISP_W-1:0] disp, input logic [2:0] idx);
    return disp[SEG_W*int'(idx) +: SEG_W];
  endfunction
endpackage

// File: rtl/seg7_scan_driver_prescaler.sv
// scan_prescaler: per-digit slot counter; tick on the last cycle of a slot, last_cycles over the blanking tail.
module scan_prescaler
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic last_cycles
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  always_comb begin
    tick = en && div_cnt_q == LAST;
    last_cycles = int'(div_cnt_q) >= CLK_DIV - BLANK_CYCLES;
    div_cnt_d = (!en || div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_d;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed six-digit 7-segment driver with per-frame shadow latch.
// Optional SEG_GHOST_BLANK_EN blanks the last BLANK_CYCLES cycles of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DISP_W-1:0] display,
  input  logic              en,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_done
);
`ifdef SEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif
  localparam logic [SEG_W-1:0] SEG_IDLE = SEG_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW != 0 ? '1 : '0;
  logic tick, last_cycles, frame_end, lit;
  logic [2:0] idx_q, idx_d;
  logic [DISP_W-1:0] shadow_q, shadow_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic frame_done_q, frame_done_d;
  scan_prescaler #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_pre (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .last_cycles(last_cycles)
  );
  // outputs are XORed with the idle level so internal logic stays active-high
  always_comb begin
    frame_end = tick && idx_q == 3'(DIGITS - 1);
    idx_d = !en ? 3'd0 : tick ? (frame_end ? 3'd0 : idx_q + 3'd1) : idx_q;
    shadow_d = (!en || frame_end) ? display : shadow_q;
    lit = en && !(GHOST && last_cycles);
    seg_d = (lit ? digit_slice(shadow_q, idx_q) : SEG_OFF) ^ SEG_IDLE;
    dig_d = (lit ? DIGITS'(1) << idx_q : '0) ^ DIG_IDLE;
    frame_done_d = frame_end;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= '0;
      shadow_q <= '0;
      seg_q <= SEG_IDLE;
      dig_q <= DIG_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      frame_done_q <= frame_done_d;
    end
  assign seg = seg_q;
  assign dig_sel = dig_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver at CLK_DIV=4 and CLK_DIV=1.
module tb_seg7_scan_driver;
`ifdef SEG_GHOST_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam logic [13:0] IDLE = {7'h7F, 6'h3F, 1'b0};
  logic clk = 1'b0;
  logic rst_n, en;
  logic [41:0] display;
  logic [6:0] seg4, seg1;
  logic [5:0] dig4, dig1;
  logic fd4, fd1;
  logic [13:0] q4[$], q1[$];
  logic [41:0] d1, d2, d3, d4;
  int n_cmp = 0, n_err = 0;
  bit chk1 = 1'b0;

  seg7_scan_driver #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_CYCLES(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .display(display), .en(en),
    .seg(seg4), .dig_sel(dig4), .frame_done(fd4));
  seg7_scan_driver #(.CLK_DIV(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .display(display), .en(en),
    .seg(seg1), .dig_sel(dig1), .frame_done(fd1));

  always #5 clk = ~clk;

  function automatic logic [13:0] ent(logic [41:0] d, int j, int div, int blk);
    int k = j / div;
    int m = j % div;
    logic [6:0] s = 7'((d >> (7 * k)) & 42'h7F);
    logic [5:0] o = 6'(1 << k);
    logic f = (j == 6 * div - 1);
    if (m >= div - blk) return {7'h7F, 6'h3F, f};
    return {~s, ~o, f};
  endfunction

  task automatic chk(string tag, logic [13:0] obs, logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push4(logic [41:0] d, int n);
    for (int j = 0; j < n; j++) q4.push_back(ent(d, j, 4, BLK));
  endtask

  task automatic push1(logic [41:0] d);
    for (int j = 0; j < 6; j++) q1.push_back(ent(d, j, 1, 0));
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) chk("div4", {seg4, dig4, fd4}, q4.pop_front());
      if (chk1 && q1.size() > 0) chk("div1", {seg1, dig1, fd1}, q1.pop_front());
    end
  endtask

  initial begin
    d1 = {7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B};
    d2 = {14'b0, 7'b0000001, 21'h1FFFFF};
    d3 = {7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F};
    d4 = 42'h2A_5A3C_96E1;
    rst_n = 1'b0;
    en = 1'b1;
    display = d1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", {seg4, dig4, fd4}, IDLE);
    chk("reset_async_div1", {seg1, dig1, fd1}, IDLE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", {seg4, dig4, fd4}, IDLE);
    end
    rst_n = 1'b1;
    push4('0, 24);
    push4(d1, 24);
    push1('0);
    push1(d1);
    push1(d1);
    chk1 = 1'b1;
    step(48);
    chk1 = 1'b0;
    push4(d1, 24);
    push4(d2, 24);
    step(10);
    display = d2;
    step(38);
    push4(d2, 14);
    step(14);
    en = 1'b0;
    repeat (4) q4.push_back(IDLE);
    step(1);
    display = d3;
    step(3);
    en = 1'b1;
    display = d4;
    push4(d3, 24);
    push4(d4, 24);
    step(48);
    chk("queue_drained", 14'(q4.size()), 14'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
